// File: rtl/multi_line_buffer.sv
// Rotating N-bank video line buffer: keeps the last LINES rows and presents the
// same-column pixels of up to LINES-1 previous rows, aligned one cycle after input.
module multi_line_buffer #(
   parameter int unsigned DW     = 24,
   parameter int unsigned H_ACT  = 1280,
   parameter int unsigned LINES  = 3,
   parameter int unsigned BORDER = 0,
   parameter int unsigned XW     = $clog2(H_ACT)
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      i_vsync,
   input  logic                      i_hsync,
   input  logic                      i_de,
   input  logic [XW-1:0]             i_x,
   input  logic [DW-1:0]             i_data,
   output logic                      o_de,
   output logic [XW-1:0]             o_x,
   output logic [DW-1:0]             o_data,
   output logic [(LINES-1)*DW-1:0]   o_taps,
   output logic [LINES-2:0]          o_tap_valid
);

   localparam int unsigned AW   = $clog2(H_ACT);
   localparam int unsigned SW   = $clog2(LINES);
   localparam int unsigned LAST = LINES - 1;

   logic [DW-1:0] mem [LINES][H_ACT];
   logic [DW-1:0] rd  [LINES];

   logic [SW-1:0] wid, wid_r, fill, fill_r, sel;
   logic          hsync_d, line_written, oor_r;
   logic          in_range, we, hs_rise;
   logic [AW-1:0] addr;
   logic [DW-1:0] last;

   assign in_range = (32'(i_x) < H_ACT);
   assign we       = i_de & in_range;
   assign addr     = AW'(i_x);
   assign hs_rise  = i_hsync & ~hsync_d;

   // Single-port banks, read-before-write; only the bank at wid is written.
   always_ff @(posedge clk) begin
      for (int b = 0; b < int'(LINES); b++) begin
         if (we && (wid == SW'(b))) mem[b][addr] <= i_data;
         rd[b] <= mem[b][addr];
      end
   end

   // Rotation and fill tracking; a line only counts if it wrote at least one pixel.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wid          <= '0;
         fill         <= '0;
         hsync_d      <= 1'b0;
         line_written <= 1'b0;
      end else begin
         hsync_d <= i_hsync;
         if (i_vsync) begin
            wid          <= '0;
            fill         <= '0;
            line_written <= 1'b0;
         end else if (hs_rise) begin
            line_written <= 1'b0;
            if (line_written) begin
               wid <= (wid == SW'(LAST)) ? '0 : wid + SW'(1);
               if (fill != SW'(LAST)) fill <= fill + SW'(1);
            end
         end else if (we) begin
            line_written <= 1'b1;
         end
      end
   end

   // Pass-through pipeline stage, registered alongside the RAM read.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         o_de   <= 1'b0;
         o_x    <= '0;
         o_data <= '0;
         wid_r  <= '0;
         fill_r <= '0;
         oor_r  <= 1'b0;
      end else begin
         o_de   <= i_de;
         o_x    <= i_x;
         o_data <= i_data;
         wid_r  <= wid;
         fill_r <= fill;
         oor_r  <= ~in_range;
      end
   end

   // Tap select; valid taps are contiguous from 0, so 'last' is the highest valid one.
   always_comb begin
      o_taps      = '0;
      o_tap_valid = '0;
      last        = o_data;
      sel         = '0;
      for (int k = 0; k < int'(LINES) - 1; k++) begin
         sel = SW'((int'(wid_r) + int'(LINES) - 1 - k) % int'(LINES));
         if (int'(fill_r) > k) begin
            o_tap_valid[k]      = 1'b1;
            o_taps[k*DW +: DW]  = rd[sel];
            last                = rd[sel];
         end else if (BORDER == 1) begin
            o_taps[k*DW +: DW]  = last;
         end
      end
      if (oor_r) o_taps = '0;
   end

endmodule

// File: tb/tb_multi_line_buffer.sv
// Bench for multi_line_buffer: three configurations share one pixel stream; a
// row-history model feeds a scoreboard, and a table pins the hand-derived checkpoints.
module tb_multi_line_buffer;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       vs = 1'b0, hs = 1'b0, de = 1'b0;
   logic [3:0] x = '0;
   logic [7:0] d = '0;

   logic        a_de, b_de, c_de;
   logic [2:0]  a_x, b_x;
   logic [3:0]  c_x;
   logic [7:0]  a_data, b_data, c_data;
   logic [15:0] a_taps, b_taps;
   logic [31:0] c_taps;
   logic [1:0]  a_valid, b_valid;
   logic [3:0]  c_valid;

   always #5 clk = ~clk;

   multi_line_buffer #(.DW(8), .H_ACT(8), .LINES(3), .BORDER(0)) u_a (
      .clk(clk), .rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_x(x[2:0]), .i_data(d),
      .o_de(a_de), .o_x(a_x), .o_data(a_data), .o_taps(a_taps), .o_tap_valid(a_valid));

   multi_line_buffer #(.DW(8), .H_ACT(8), .LINES(3), .BORDER(1)) u_b (
      .clk(clk), .rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_x(x[2:0]), .i_data(d),
      .o_de(b_de), .o_x(b_x), .o_data(b_data), .o_taps(b_taps), .o_tap_valid(b_valid));

   multi_line_buffer #(.DW(8), .H_ACT(8), .LINES(5), .BORDER(0), .XW(4)) u_c (
      .clk(clk), .rstn(rstn), .i_vsync(vs), .i_hsync(hs), .i_de(de), .i_x(x), .i_data(d),
      .o_de(c_de), .o_x(c_x), .o_data(c_data), .o_taps(c_taps), .o_tap_valid(c_valid));

   typedef struct {
      logic        de;
      logic [3:0]  x;
      logic [7:0]  data;
      logic [15:0] a_taps;
      logic [1:0]  a_valid;
      logic [15:0] b_taps;
      logic [1:0]  b_valid;
      logic [31:0] c_taps;
      logic [3:0]  c_valid;
      bit          chk_ab;
      int          frame;
      int          row;
      int          px;
   } exp_t;

   typedef struct {
      int          frame;
      int          row;
      int          px;
      logic [15:0] a_taps;
      logic [1:0]  a_valid;
      logic [15:0] b_taps;
      logic [31:0] c_taps;
      logic [3:0]  c_valid;
   } vec_t;

   exp_t sb[$];
   vec_t tbl[9];
   int   rows_done[$];
   int   cur_row = 0;
   int   frame = 1;
   bit   row_written = 1'b0;
   bit   hs_prev = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;
   int   n_tbl_hit = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s (frame %0d row %0d): got %h, expected %h", nm, frame, cur_row, act, exp);
      end
   endtask

   // Expected {valid, taps} from the list of completed rows of this frame.
   function automatic logic [35:0] model(input int lines, input bit border, input int px,
                                         input logic [7:0] pd, input bit oor);
      logic [31:0] t = '0;
      logic [3:0]  v = '0;
      logic [7:0]  lastv = pd;
      logic [7:0]  tv;
      int          n = rows_done.size();
      for (int k = 0; k < lines - 1; k++) begin
         if (k < n) begin
            tv          = 8'(rows_done[n-1-k] * 16 + px);
            t[k*8 +: 8] = tv;
            v[k]        = 1'b1;
            lastv       = tv;
         end else if (border) begin
            t[k*8 +: 8] = lastv;
         end
      end
      if (oor) t = '0;
      return {v, t};
   endfunction

   task automatic step(input bit s_de, input bit s_hs, input bit s_vs, input int px, input bit chk_ab);
      exp_t        e;
      logic [35:0] m;
      bit          oor;
      de  = s_de;
      hs  = s_hs;
      vs  = s_vs;
      x   = 4'(px);
      d   = 8'(cur_row * 16 + px);
      oor = (px >= 8);
      e.de = s_de; e.x = x; e.data = d; e.chk_ab = chk_ab;
      e.frame = frame; e.row = cur_row; e.px = px;
      m = model(3, 1'b0, px, d, oor); e.a_taps = m[15:0]; e.a_valid = m[33:32];
      m = model(3, 1'b1, px, d, oor); e.b_taps = m[15:0]; e.b_valid = m[33:32];
      m = model(5, 1'b0, px, d, oor); e.c_taps = m[31:0]; e.c_valid = m[35:32];
      sb.push_back(e);

      @(negedge clk);
      e = sb.pop_front();
      check("c_de", 32'(c_de), 32'(e.de));
      if (e.chk_ab) begin
         check("a_de", 32'(a_de), 32'(e.de));
         check("b_de", 32'(b_de), 32'(e.de));
      end
      if (e.de) begin
         check("c_data", 32'(c_data), 32'(e.data));
         check("c_x", 32'(c_x), 32'(e.x));
         check("c_taps", c_taps, e.c_taps);
         check("c_valid", 32'(c_valid), 32'(e.c_valid));
         if (e.chk_ab) begin
            check("a_data", 32'(a_data), 32'(e.data));
            check("a_taps", 32'(a_taps), 32'(e.a_taps));
            check("a_valid", 32'(a_valid), 32'(e.a_valid));
            check("b_taps", 32'(b_taps), 32'(e.b_taps));
            check("b_valid", 32'(b_valid), 32'(e.b_valid));
            for (int i = 0; i < 9; i++) begin
               if (tbl[i].frame == e.frame && tbl[i].row == e.row && tbl[i].px == e.px) begin
                  n_tbl_hit++;
                  check("tbl_a_taps", 32'(a_taps), 32'(tbl[i].a_taps));
                  check("tbl_a_valid", 32'(a_valid), 32'(tbl[i].a_valid));
                  check("tbl_b_taps", 32'(b_taps), 32'(tbl[i].b_taps));
                  check("tbl_c_taps", c_taps, tbl[i].c_taps);
                  check("tbl_c_valid", 32'(c_valid), 32'(tbl[i].c_valid));
               end
            end
         end
      end

      if (s_vs) begin
         rows_done.delete();
         row_written = 1'b0;
      end else if (s_hs && !hs_prev) begin
         if (row_written) rows_done.push_back(cur_row);
         row_written = 1'b0;
      end else if (s_de && !oor) begin
         row_written = 1'b1;
      end
      hs_prev = s_hs;
   endtask

   task automatic hsync_pulse();
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic do_row();
      for (int px = 0; px < 8; px++) step(1'b1, 1'b0, 1'b0, px, 1'b1);
      hsync_pulse();
      cur_row++;
   endtask

   task automatic vsync_pulse();
      step(1'b0, 1'b0, 1'b1, 0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);
      cur_row = 0;
      frame++;
   endtask

   initial begin
      //           frame row x   a_taps    a_v    b_taps    c_taps         c_v
      tbl[0] = '{1, 0, 3, 16'h0000, 2'b00, 16'h0303, 32'h00000000, 4'b0000};
      tbl[1] = '{1, 1, 3, 16'h0003, 2'b01, 16'h0303, 32'h00000003, 4'b0001};
      tbl[2] = '{1, 2, 3, 16'h0313, 2'b11, 16'h0313, 32'h00000313, 4'b0011};
      tbl[3] = '{1, 4, 4, 16'h2434, 2'b11, 16'h2434, 32'h04142434, 4'b1111};
      tbl[4] = '{1, 5, 3, 16'h3343, 2'b11, 16'h3343, 32'h13233343, 4'b1111};
      tbl[5] = '{1, 6, 2, 16'h4252, 2'b11, 16'h4252, 32'h22324252, 4'b1111};
      tbl[6] = '{1, 7, 7, 16'h5767, 2'b11, 16'h5767, 32'h37475767, 4'b1111};
      tbl[7] = '{2, 1, 3, 16'h0003, 2'b01, 16'h0303, 32'h00000003, 4'b0001};
      tbl[8] = '{3, 0, 5, 16'h0000, 2'b00, 16'h0505, 32'h00000000, 4'b0000};

      // Reset held while pixels are driven: every output stays at zero.
      de = 1'b1; d = 8'hFF; x = 4'd3;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_a_de", 32'(a_de), 32'd0);
      check("rst_a_data", 32'(a_data), 32'd0);
      check("rst_a_taps", 32'(a_taps), 32'd0);
      check("rst_b_taps", 32'(b_taps), 32'd0);
      check("rst_c_taps", c_taps, 32'd0);
      check("rst_c_valid", 32'(c_valid), 32'd0);
      check("rst_c_x", 32'(c_x), 32'd0);
      de = 1'b0;
      rstn = 1'b1;
      step(1'b0, 1'b0, 1'b0, 0, 1'b1);

      // Frame 1: rows 0..7 with four empty hsync lines between rows 3 and 4.
      for (int r = 0; r < 8; r++) begin
         do_row();
         if (r == 3) repeat (4) hsync_pulse();
      end

      // Frame 2 is cut short by vsync; frame 3 starts over with nothing valid.
      vsync_pulse();
      do_row();
      do_row();
      vsync_pulse();
      do_row();
      do_row();
      do_row();

      // Out-of-range column on the wide-index instance: taps zero, pixel passes through.
      step(1'b1, 1'b0, 1'b0, 9, 1'b0);
      step(1'b1, 1'b0, 1'b0, 2, 1'b0);
      check("tbl_hits", 32'(n_tbl_hit), 32'd9);

      // Asynchronous reset clears the registered outputs without a clock edge.
      #2 rstn = 1'b0;
      #1;
      check("async_c_de", 32'(c_de), 32'd0);
      check("async_c_data", 32'(c_data), 32'd0);
      check("async_c_valid", 32'(c_valid), 32'd0);
      check("async_a_taps", 32'(a_taps), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
